// File: rtl/assoc_tag_mem_pkg.sv
// ============================================================================
// Module  : assoc_tag_mem_pkg
// Brief   : Shared sizing defaults, count-width helper and wb_hit encoding
//           used by the associative tag memory.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package assoc_tag_mem_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_TAG_W  = 3;
    localparam int DEF_DATA_W = 3;

    localparam logic WB_UPDATE = 1'b1;
    localparam logic WB_ALLOC  = 1'b0;

    // Width needed to hold a count from 0 up to and including depth
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/assoc_tag_mem_match.sv
// ============================================================================
// Module  : assoc_tag_mem_match
// Brief   : Fully associative compare of one tag against all valid entries;
//           the lowest-index match wins.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module assoc_tag_mem_match
    import assoc_tag_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAG_W = DEF_TAG_W,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]       i_valid,
    input  logic [DEPTH*TAG_W-1:0] i_tags,
    input  logic [TAG_W-1:0]       i_tag,
    output logic                   o_hit,
    output logic [DEPTH-1:0]       o_onehot,
    output logic [IDX_W-1:0]       o_idx
);

    logic [DEPTH-1:0] w_match;

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        assign w_match[i] = i_valid[i] && (i_tags[i*TAG_W +: TAG_W] == i_tag);
    end

    assign o_hit    = |w_match;
    // Isolate the lowest set bit
    assign o_onehot = w_match & (~w_match + DEPTH'(1));

    always_comb begin
        o_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/assoc_tag_mem.sv
// ============================================================================
// Module  : assoc_tag_mem
// Brief   : Clocked fully associative tag/data memory with hit reporting,
//           allocate-on-miss write-back, round-robin eviction and flush.
//           Define ASSOC_TAG_MEM_BYPASS_EN to forward a same-edge write-back
//           to a read of the same tag.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module assoc_tag_mem
    import assoc_tag_mem_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        rd_en,
    input  logic [TAG_W-1:0]            rd_tag,
    output logic                        rd_valid,
    output logic                        rd_hit,
    output logic [DATA_W-1:0]           rd_data,
    input  logic                        wb_en,
    input  logic [TAG_W-1:0]            wb_tag,
    input  logic [DATA_W-1:0]           wb_data,
    output logic                        wb_hit,
    input  logic                        flush,
    output logic [count_w(DEPTH)-1:0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = count_w(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [IDX_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_rd_valid;
    logic              r_rd_hit;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_wb_hit;

    logic [DEPTH*TAG_W-1:0] w_tags;
    logic                   w_rd_hit, w_wb_hit;
    logic [DEPTH-1:0]       w_rd_onehot, w_wb_onehot;
    logic [IDX_W-1:0]       w_rd_idx, w_wb_idx;
    logic [IDX_W-1:0]       w_free_idx, w_wr_idx;
    logic                   w_full, w_wr;
    logic                   w_rsp_hit;
    logic [DATA_W-1:0]      w_rsp_data;
    logic                   w_unused;

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign w_tags[i*TAG_W +: TAG_W] = r_tag[i];
    end

    assoc_tag_mem_match #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_rd_match (
        .i_valid  (r_valid),
        .i_tags   (w_tags),
        .i_tag    (rd_tag),
        .o_hit    (w_rd_hit),
        .o_onehot (w_rd_onehot),
        .o_idx    (w_rd_idx)
    );

    assoc_tag_mem_match #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_wb_match (
        .i_valid  (r_valid),
        .i_tags   (w_tags),
        .i_tag    (wb_tag),
        .o_hit    (w_wb_hit),
        .o_onehot (w_wb_onehot),
        .o_idx    (w_wb_idx)
    );

    // Only the encoded index is needed on both ports
    assign w_unused = ^{w_rd_onehot, w_wb_onehot};

    // Lowest-index free slot
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
        end
    end

    assign w_full   = &r_valid;
    assign w_wr     = wb_en && !flush;
    assign w_wr_idx = w_wb_hit ? w_wb_idx : (w_full ? r_ptr : w_free_idx);

    always_comb begin
        w_rsp_hit  = w_rd_hit;
        w_rsp_data = w_rd_hit ? r_data[w_rd_idx] : '0;
`ifdef ASSOC_TAG_MEM_BYPASS_EN
        if (wb_en && (rd_tag == wb_tag)) begin
            w_rsp_hit  = 1'b1;
            w_rsp_data = wb_data;
        end
`endif
        if (flush) begin
            w_rsp_hit  = 1'b0;
            w_rsp_data = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= '0;
            r_ptr      <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_hit   <= 1'b0;
            r_rd_data  <= '0;
            r_wb_hit   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_hit  <= w_rsp_hit;
                r_rd_data <= w_rsp_data;
            end
            if (flush) begin
                r_valid <= '0;
                r_ptr   <= '0;
                r_count <= '0;
            end else if (wb_en) begin
                r_wb_hit <= w_wb_hit ? WB_UPDATE : WB_ALLOC;
                if (!w_wb_hit) begin
                    r_valid[w_wr_idx] <= 1'b1;
                    if (w_full) begin
                        r_ptr <= (r_ptr == IDX_W'(DEPTH - 1)) ? '0 : r_ptr + IDX_W'(1);
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Tag/data storage carries no reset; validity lives in r_valid
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_tag[w_wr_idx]  <= wb_tag;
            r_data[w_wr_idx] <= wb_data;
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_hit   = r_rd_hit;
    assign rd_data  = r_rd_data;
    assign wb_hit   = r_wb_hit;
    assign count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_assoc_tag_mem.sv
// ============================================================================
// Module  : tb_assoc_tag_mem
// Brief   : Self-checking bench for assoc_tag_mem (DEPTH=4) against a
//           behavioural model; honours ASSOC_TAG_MEM_BYPASS_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_assoc_tag_mem;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 3;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              rd_en = 1'b0;
    logic [TAG_W-1:0]  rd_tag = '0;
    logic              rd_valid;
    logic              rd_hit;
    logic [DATA_W-1:0] rd_data;
    logic              wb_en = 1'b0;
    logic [TAG_W-1:0]  wb_tag = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              wb_hit;
    logic              flush = 1'b0;
    logic [2:0]        count;

    int n_checks = 0;
    int n_errors = 0;

    assoc_tag_mem #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd_en    (rd_en),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_hit   (rd_hit),
        .rd_data  (rd_data),
        .wb_en    (wb_en),
        .wb_tag   (wb_tag),
        .wb_data  (wb_data),
        .wb_hit   (wb_hit),
        .flush    (flush),
        .count    (count)
    );

    always #5 clock = ~clock;

    // Behavioural model: a small table of entries plus a replacement pointer
    bit   m_valid [DEPTH];
    int   m_tag   [DEPTH];
    int   m_data  [DEPTH];
    int   m_ptr;
    int   e_rd_valid, e_rd_hit, e_rd_data, e_wb_hit, e_count;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int find(input int t);
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        m_ptr = 0;
        e_rd_valid = 0; e_rd_hit = 0; e_rd_data = 0; e_wb_hit = 0; e_count = 0;
    endtask

    task automatic model_step();
        int i, slot;
        if (!reset_n) return;
        e_rd_valid = int'(rd_en);
        if (rd_en) begin
            if (flush) begin
                e_rd_hit = 0; e_rd_data = 0;
            end else begin
                i = find(int'(rd_tag));
                e_rd_hit  = (i >= 0) ? 1 : 0;
                e_rd_data = (i >= 0) ? m_data[i] : 0;
`ifdef ASSOC_TAG_MEM_BYPASS_EN
                if (wb_en && rd_tag == wb_tag) begin
                    e_rd_hit = 1; e_rd_data = int'(wb_data);
                end
`endif
            end
        end
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) m_valid[k] = 0;
            m_ptr = 0;
        end else if (wb_en) begin
            i = find(int'(wb_tag));
            if (i >= 0) begin
                m_data[i] = int'(wb_data);
                e_wb_hit = 1;
            end else begin
                slot = -1;
                for (int k = DEPTH - 1; k >= 0; k--) if (!m_valid[k]) slot = k;
                if (slot < 0) begin
                    slot  = m_ptr;
                    m_ptr = (m_ptr + 1) % DEPTH;
                end
                m_valid[slot] = 1;
                m_tag[slot]   = int'(wb_tag);
                m_data[slot]  = int'(wb_data);
                e_wb_hit = 0;
            end
        end
        e_count = 0;
        for (int k = 0; k < DEPTH; k++) e_count += int'(m_valid[k]);
    endtask

    always @(negedge clock) begin
        chk("rd_valid", int'(rd_valid), e_rd_valid);
        chk("rd_hit",   int'(rd_hit),   e_rd_hit);
        chk("rd_data",  int'(rd_data),  e_rd_data);
        chk("wb_hit",   int'(wb_hit),   e_wb_hit);
        chk("count",    int'(count),    e_count);
    end

    // One clock: drive at negedge, model at posedge, return at next negedge
    task automatic cycle(input bit re, input int rt, input bit we, input int wt,
                         input int wd, input bit fl);
        rd_en = re; rd_tag = TAG_W'(rt);
        wb_en = we; wb_tag = TAG_W'(wt); wb_data = DATA_W'(wd);
        flush = fl;
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic rd(input int t);             cycle(1, t, 0, 0, 0, 0); endtask
    task automatic wb(input int t, input int d); cycle(0, 0, 1, t, d, 0); endtask
    task automatic idle();                       cycle(0, 0, 0, 0, 0, 0); endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_count",    int'(count),    0);
        reset_n = 1'b1;

        // Empty lookup
        rd(2);
        chk("s1_rd_valid", int'(rd_valid), 1);
        chk("s1_rd_hit",   int'(rd_hit),   0);
        chk("s1_rd_data",  int'(rd_data),  0);
        chk("s1_count",    int'(count),    0);
        idle();
        chk("s1_pulse",    int'(rd_valid), 0);

        // Allocate then update
        wb(1, 5);
        rd(1);
        chk("s2_hit",   int'(rd_hit),  1);
        chk("s2_data",  int'(rd_data), 5);
        chk("s2_count", int'(count),   1);
        chk("s2_wbhit", int'(wb_hit),  0);
        wb(1, 3);
        chk("s2_upd_wbhit", int'(wb_hit), 1);
        chk("s2_upd_count", int'(count),  1);
        rd(1);
        chk("s2_upd_data",  int'(rd_data), 3);

        // Fill and round-robin eviction
        cycle(0, 0, 0, 0, 0, 1);
        for (int t = 1; t <= 4; t++) wb(t, t);
        chk("s3_full_count", int'(count), 4);
        wb(5, 5);
        chk("s3_evict_count", int'(count), 4);
        rd(1); chk("s3_tag1_gone", int'(rd_hit), 0);
        rd(2); chk("s3_tag2_kept", int'(rd_hit), 1);
        wb(6, 6);
        rd(2); chk("s3_tag2_gone", int'(rd_hit), 0);
        rd(3); chk("s3_tag3_kept", int'(rd_hit), 1);
        wb(7, 7);
        wb(0, 0);
        rd(3); chk("s3_tag3_gone", int'(rd_hit), 0);
        rd(0); chk("s3_tag0_hit",  int'(rd_hit), 1);
        chk("s3_tag0_data", int'(rd_data), 0);
        wb(1, 1);
        rd(5); chk("s3_wrap_tag5_gone", int'(rd_hit), 0);
        rd(6); chk("s3_wrap_tag6_kept", int'(rd_data), 6);

        // Same-edge read and write-back
        wb(6, 1);
        cycle(1, 6, 1, 6, 4, 0);
        chk("s4_same_edge_hit", int'(rd_hit), 1);
`ifdef ASSOC_TAG_MEM_BYPASS_EN
        chk("s4_same_edge_data", int'(rd_data), 4);
`else
        chk("s4_same_edge_data", int'(rd_data), 1);
`endif
        rd(6); chk("s4_after_data", int'(rd_data), 4);

        // Flush beats concurrent read and write-back
        cycle(1, 2, 1, 2, 3, 1);
        chk("s5_rd_valid", int'(rd_valid), 1);
        chk("s5_rd_hit",   int'(rd_hit),   0);
        chk("s5_rd_data",  int'(rd_data),  0);
        chk("s5_count",    int'(count),    0);
        chk("s5_wbhit_hold", int'(wb_hit), 1);
        rd(2); chk("s5_tag2_miss", int'(rd_hit), 0);
        for (int t = 1; t <= 4; t++) wb(t, t);
        wb(5, 5);
        rd(1); chk("s5_ptr0_evicts_slot0", int'(rd_hit), 0);
        rd(2); chk("s5_slot1_kept",        int'(rd_hit), 1);

        // Asynchronous reset with a response in flight
        rd_en = 1'b1; rd_tag = 3'd2;
        @(posedge clock);
        model_step();
        rd_en = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("s6_async_rd_valid", int'(rd_valid), 0);
        chk("s6_async_rd_hit",   int'(rd_hit),   0);
        chk("s6_async_count",    int'(count),    0);
        @(negedge clock);
        idle();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("s6_no_pulse", int'(rd_valid), 0);
        end

        // Randomized traffic; a tag space larger than DEPTH forces evictions
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), ($urandom_range(0, 31) == 0));
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
